// File: rtl/rotate_fb_scheduler.sv
// Frame-buffer scheduler for the screen rotator: hands writer and reader a buffer index and base
// address at each frame boundary. Define ROTATE_FB_TRIPLE_EN for three tear-free buffers (default: two).
module rotate_fb_scheduler #(
    parameter int unsigned BUFSIZE = 76800,
    parameter int unsigned AW      = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_frame_start,
    input  logic          wr_abort,
    input  logic          rd_frame_start,
    output logic [1:0]    wr_buf,
    output logic [AW-1:0] wr_base,
    output logic [1:0]    rd_buf,
    output logic [AW-1:0] rd_base,
    output logic          rd_valid,
    output logic          rd_new,
    output logic          rd_repeat,
    output logic          frame_drop,
    output logic [7:0]    drop_cnt
);

    localparam logic [AW-1:0] BASE1 = AW'(BUFSIZE);
`ifdef ROTATE_FB_TRIPLE_EN
    localparam logic [AW-1:0] BASE2 = AW'(2 * BUFSIZE);
`endif

    function automatic logic [AW-1:0] base_of(input logic [1:0] idx);
        case (idx)
            2'd1:    base_of = BASE1;
`ifdef ROTATE_FB_TRIPLE_EN
            2'd2:    base_of = BASE2;
`endif
            default: base_of = '0;
        endcase
    endfunction

`ifdef ROTATE_FB_TRIPLE_EN
    // Lowest buffer index held by neither the reader nor the latest completed frame.
    function automatic logic [1:0] pick_free(input logic [1:0] a, input logic [1:0] b);
        if (a != 2'd0 && b != 2'd0)
            pick_free = 2'd0;
        else if (a != 2'd1 && b != 2'd1)
            pick_free = 2'd1;
        else
            pick_free = 2'd2;
    endfunction
`endif

    logic [1:0]    w_q, w_d, r_q, r_d, l_q, l_d;
    logic          fresh_q, fresh_d;
    logic          wr_active_q, wr_active_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_new_q, rd_new_d;
    logic          rd_repeat_q, rd_repeat_d;
    logic          frame_drop_q, frame_drop_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [AW-1:0] wr_base_q, rd_base_q;
    logic          complete;

    // NOTE: combinational next-state uses blocking '=' with every output defaulted first, so
    // later statements see earlier updates (writer before reader) and no latch is inferred.
    always_comb begin
        w_d          = w_q;
        r_d          = r_q;
        l_d          = l_q;
        fresh_d      = fresh_q;
        wr_active_d  = wr_active_q;
        rd_valid_d   = rd_valid_q;
        rd_new_d     = 1'b0;
        rd_repeat_d  = 1'b0;
        frame_drop_d = 1'b0;
        drop_cnt_d   = drop_cnt_q;

        // An abort in the same cycle as a frame start discards the frame instead of publishing it.
        complete = wr_frame_start && wr_active_q && !wr_abort;

        if (complete) begin
            l_d     = w_q;
            fresh_d = 1'b1;
            if (fresh_q) begin
                frame_drop_d = 1'b1;
                if (drop_cnt_q != 8'hFF)
                    drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        if (wr_frame_start)
            wr_active_d = 1'b1;
        else if (wr_abort)
            wr_active_d = 1'b0;

        if (rd_frame_start) begin
            if (fresh_d) begin
                r_d        = l_d;
                fresh_d    = 1'b0;
                rd_valid_d = 1'b1;
                rd_new_d   = 1'b1;
            end else if (rd_valid_q) begin
                rd_repeat_d = 1'b1;
            end
        end

        if (complete) begin
`ifdef ROTATE_FB_TRIPLE_EN
            w_d = pick_free(r_d, l_d);
`else
            w_d = {1'b0, ~w_q[0]};
`endif
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_q          <= 2'd0;
            r_q          <= 2'd1;
            l_q          <= 2'd1;
            fresh_q      <= 1'b0;
            wr_active_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_new_q     <= 1'b0;
            rd_repeat_q  <= 1'b0;
            frame_drop_q <= 1'b0;
            drop_cnt_q   <= 8'd0;
            wr_base_q    <= '0;
            rd_base_q    <= BASE1;
        end else begin
            w_q          <= w_d;
            r_q          <= r_d;
            l_q          <= l_d;
            fresh_q      <= fresh_d;
            wr_active_q  <= wr_active_d;
            rd_valid_q   <= rd_valid_d;
            rd_new_q     <= rd_new_d;
            rd_repeat_q  <= rd_repeat_d;
            frame_drop_q <= frame_drop_d;
            drop_cnt_q   <= drop_cnt_d;
            wr_base_q    <= base_of(w_d);
            rd_base_q    <= base_of(r_d);
        end
    end

    assign wr_buf     = w_q;
    assign wr_base    = wr_base_q;
    assign rd_buf     = r_q;
    assign rd_base    = rd_base_q;
    assign rd_valid   = rd_valid_q;
    assign rd_new     = rd_new_q;
    assign rd_repeat  = rd_repeat_q;
    assign frame_drop = frame_drop_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_rotate_fb_scheduler.sv
// Self-checking bench for rotate_fb_scheduler: event-level reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_rotate_fb_scheduler;

    localparam int BUFSIZE = 76800;
    localparam int AW      = 18;

    logic          clk = 1'b0;
    logic          reset, wr_frame_start, wr_abort, rd_frame_start;
    logic [1:0]    wr_buf, rd_buf;
    logic [AW-1:0] wr_base, rd_base;
    logic          rd_valid, rd_new, rd_repeat, frame_drop;
    logic [7:0]    drop_cnt;

    int checks   = 0;
    int failures = 0;

    rotate_fb_scheduler #(.BUFSIZE(BUFSIZE), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .wr_frame_start(wr_frame_start), .wr_abort(wr_abort), .rd_frame_start(rd_frame_start),
        .wr_buf(wr_buf), .wr_base(wr_base), .rd_buf(rd_buf), .rd_base(rd_base),
        .rd_valid(rd_valid), .rd_new(rd_new), .rd_repeat(rd_repeat),
        .frame_drop(frame_drop), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one frame event at a time, writer first, then reader.
    int m_w, m_r, m_l, m_cnt;
    bit m_fresh, m_act, m_valid, m_new, m_rep, m_drop;
    bit m_ok = 1'b0;

`ifdef ROTATE_FB_TRIPLE_EN
    localparam int NBUF = 3;
`else
    localparam int NBUF = 2;
`endif

    always @(posedge clk) begin
        bit done;
        if (reset) begin
            m_w = 0; m_r = 1; m_l = 1; m_cnt = 0;
            m_fresh = 0; m_act = 0; m_valid = 0;
            m_new = 0; m_rep = 0; m_drop = 0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            done   = wr_frame_start && m_act && !wr_abort;
            m_new  = 0; m_rep = 0; m_drop = 0;
            if (done) begin
                if (m_fresh) begin
                    m_drop = 1;
                    m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
                end
                m_l     = m_w;
                m_fresh = 1;
            end
            if (wr_frame_start) m_act = 1;
            else if (wr_abort)  m_act = 0;
            if (rd_frame_start) begin
                if (m_fresh) begin
                    m_r = m_l; m_fresh = 0; m_valid = 1; m_new = 1;
                end else if (m_valid) begin
                    m_rep = 1;
                end
            end
            if (done) begin
                if (NBUF == 3) begin
                    for (int k = 2; k >= 0; k--)
                        if (k != m_r && k != m_l) m_w = k;
                end else begin
                    m_w = 1 - m_w;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("wr_buf", 32'(wr_buf), 32'(m_w));
            check("wr_base", 32'(wr_base), 32'(m_w * BUFSIZE));
            check("rd_buf", 32'(rd_buf), 32'(m_r));
            check("rd_base", 32'(rd_base), 32'(m_r * BUFSIZE));
            check("rd_valid", 32'(rd_valid), 32'(m_valid));
            check("rd_new", 32'(rd_new), 32'(m_new));
            check("rd_repeat", 32'(rd_repeat), 32'(m_rep));
            check("frame_drop", 32'(frame_drop), 32'(m_drop));
            check("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
`ifdef ROTATE_FB_TRIPLE_EN
            check("w_ne_r", 32'(wr_buf != rd_buf), 32'd1);
`endif
        end
    end

    task automatic cyc(input bit wfs, input bit ab, input bit rfs, input bit rst);
        wr_frame_start = wfs;
        wr_abort       = ab;
        rd_frame_start = rfs;
        reset          = rst;
        @(negedge clk);
    endtask

    task automatic reset_literals(input string tag);
        check({tag, "_wr_buf"}, 32'(wr_buf), 32'd0);
        check({tag, "_wr_base"}, 32'(wr_base), 32'd0);
        check({tag, "_rd_buf"}, 32'(rd_buf), 32'd1);
        check({tag, "_rd_base"}, 32'(rd_base), 32'd76800);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_pulses"}, 32'({rd_new, rd_repeat, frame_drop}), 32'd0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        wr_frame_start = 0; wr_abort = 0; rd_frame_start = 0; reset = 1;
        @(negedge clk);
        cyc(0, 0, 0, 1);
        reset_literals("reset");

        // Three writer frames, then one reader frame.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("t1_frame_drop", 32'(frame_drop), 32'd1);
        check("t1_drop_cnt", 32'(drop_cnt), 32'd1);
        cyc(0, 0, 1, 0);
        check("t1_rd_new", 32'(rd_new), 32'd1);
        check("t1_rd_valid", 32'(rd_valid), 32'd1);
        check("t1_wr_buf", 32'(wr_buf), 32'd0);
`ifdef ROTATE_FB_TRIPLE_EN
        check("t1_rd_buf", 32'(rd_buf), 32'd2);
        check("t1_rd_base", 32'(rd_base), 32'd153600);
`else
        check("t1_rd_buf", 32'(rd_buf), 32'd1);
        check("t1_rd_base", 32'(rd_base), 32'd76800);
`endif

        // Abort, restart: nothing published, reader repeats.
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        check("t4_no_drop", 32'(frame_drop), 32'd0);
        cyc(0, 0, 1, 0);
        check("t4_rd_repeat", 32'(rd_repeat), 32'd1);
        check("t4_rd_new", 32'(rd_new), 32'd0);

        // Writer completion and reader start together: reader takes the just-finished buffer 0.
        cyc(1, 0, 1, 0);
        check("t5_rd_new", 32'(rd_new), 32'd1);
        check("t5_rd_buf", 32'(rd_buf), 32'd0);
        check("t5_frame_drop", 32'(frame_drop), 32'd0);
        check("t5_wr_buf", 32'(wr_buf), 32'd1);

        // Writer at twice the reader rate, then reader at twice the writer rate.
        for (int i = 0; i < 64; i++) cyc(i % 2 == 0, 0, i % 4 == 3, 0);
        for (int i = 0; i < 64; i++) cyc(i % 4 == 0, 0, i % 2 == 1, 0);

        // Random traffic with occasional aborts and resets.
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0);

        // Drive the drop counter into saturation, then reset mid-stream.
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
        check("t6_drop_sat", 32'(drop_cnt), 32'd255);
        cyc(1, 0, 0, 0);
        check("t6_drop_hold", 32'(drop_cnt), 32'd255);
        cyc(1, 1, 1, 1);
        reset_literals("midrst");
        cyc(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
